// File: rtl/uart_result_tx.sv
// Sends a 16-bit ALU result as NUM_BYTES 8N1 UART bytes, low byte first.
// Define UART_RESULT_TX_PARITY_EN to append an even-parity bit to every byte.
module uart_result_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_BYTES    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ena,
  input  logic        start,
  input  logic [15:0] data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic LAST_BYTE = 1'(NUM_BYTES - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RESULT_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic              byte_q, byte_d;
  logic [15:0]       shreg_q, shreg_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              baud_end;
`ifdef UART_RESULT_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_RESULT_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (ena) begin
      if (state_q != IDLE) baud_d = baud_end ? '0 : baud_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = START;
            shreg_d = data;
            byte_d  = 1'b0;
            bit_d   = 3'd0;
            baud_d  = '0;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
          end
        end
        START: begin
          if (baud_end) begin
            state_d = DATA;
            bit_d   = 3'd0;
            tx_d    = shreg_q[0];
`ifdef UART_RESULT_TX_PARITY_EN
            par_d   = ^shreg_q[7:0];
`endif
          end
        end
        DATA: begin
          // Shifting once per data bit leaves the next byte in [7:0] after bit 7.
          if (baud_end) begin
            shreg_d = {1'b0, shreg_q[15:1]};
            if (bit_q == 3'd7) begin
`ifdef UART_RESULT_TX_PARITY_EN
              state_d = PARITY;
              tx_d    = par_q;
`else
              state_d = STOP;
              tx_d    = 1'b1;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
              tx_d  = shreg_q[1];
            end
          end
        end
`ifdef UART_RESULT_TX_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_end) begin
            if (byte_q != LAST_BYTE) begin
              byte_d  = byte_q + 1'b1;
              state_d = START;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          baud_d  = '0;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Payload registers carry no reset; they are only read once a frame is accepted.
  always_ff @(posedge clock) begin
    shreg_q <= shreg_d;
`ifdef UART_RESULT_TX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_result_tx.sv
// Scoreboard bench for uart_result_tx: a frame-level model queues accepted words,
// a monitor rebuilds each frame's tx waveform and compares it on done.
module tb_uart_result_tx;

  localparam int CPB = 4;
  localparam int NB  = 2;
`ifdef UART_RESULT_TX_PARITY_EN
  localparam int BPB = 11;
`else
  localparam int BPB = 10;
`endif
  localparam int FRAME = NB * BPB * CPB;

  logic        clock = 1'b0;
  logic        reset;
  logic        ena;
  logic        start;
  logic [15:0] data;
  logic        tx;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  uart_result_tx #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB)) dut (
    .clock(clock),
    .reset(reset),
    .ena  (ena),
    .start(start),
    .data (data),
    .tx   (tx),
    .busy (busy),
    .done (done)
  );

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Expected line level for enabled-cycle index idx of a frame carrying d.
  function automatic logic exp_level(input logic [15:0] d, input int idx);
    int bitpos, bytei, k;
    logic [7:0] b;
    bitpos = idx / CPB;
    bytei  = bitpos / BPB;
    k      = bitpos % BPB;
    b      = (bytei == 0) ? d[7:0] : d[15:8];
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && BPB == 11) return ^b;
    return 1'b1;
  endfunction

  // Reference model: a frame occupies FRAME enabled cycles after acceptance.
  logic [15:0] exp_q[$];
  int   rem      = 0;
  logic exp_busy = 1'b0;
  logic exp_done = 1'b0;

  always @(posedge clock or posedge reset) begin : model
    int   r;
    logic d;
    if (reset) begin
      rem      <= 0;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      exp_q.delete();
    end else begin
      r = rem;
      d = 1'b0;
      if (ena) begin
        if (r == 0) begin
          if (start) begin
            exp_q.push_back(data);
            r = FRAME;
          end
        end else begin
          r = r - 1;
          if (r == 0) d = 1'b1;
        end
      end
      rem      <= r;
      exp_done <= d;
      exp_busy <= (r != 0);
    end
  end

  logic trace[$];

  always @(negedge clock) begin : monitor
    logic [15:0] w;
    int          bad;
    if (reset) begin
      trace.delete();
    end else begin
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      if (!exp_busy) check("tx_idle", tx, 1'b1);
      if (busy && ena) trace.push_back(tx);
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL frame_pop: done pulse with no frame expected at %0t", $time);
        end else begin
          w = exp_q.pop_front();
          check_int("frame_len", trace.size(), FRAME);
          bad = 0;
          for (int i = 0; i < trace.size() && i < FRAME; i++)
            if (trace[i] !== exp_level(w, i)) bad++;
          n_checks++;
          if (bad == 0) n_pass++;
          else $display("FAIL frame_bits: data %h has %0d wrong tx cycles, required 0", w, bad);
        end
        trace.delete();
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] d);
    start = 1'b1;
    data  = d;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (!done && n < 4 * FRAME) begin
      tick();
      n++;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL %s: no done pulse after %0d cycles, required within %0d", name, n, 4 * FRAME);
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int dones;
    reset = 1'b1;
    ena   = 1'b1;
    start = 1'b0;
    data  = 16'h0000;
    tick(3);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b0;
    tick(2);

    send(16'h00A5);
    check("first_tx", tx, 1'b0);
    check("first_busy", busy, 1'b1);
    wait_done("basic", n);
    check_int("basic_latency", n, FRAME);
    tick(3);

    send(16'h1234);
    tick(8);
    send(16'hFFFF);
    wait_done("ignored", n);
    tick();
    dones = 0;
    repeat (FRAME + 10) begin
      tick();
      if (done) dones++;
    end
    check_int("single_done", dones, 0);
    check_int("queue_after_ignored", exp_q.size(), 0);

    send(16'hBEEF);
    tick(23);
    #2 reset = 1'b1;
    #1;
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    tick(2);
    reset = 1'b0;
    tick(2);
    send(16'h0001);
    wait_done("after_reset", n);
    check_int("after_reset_latency", n, FRAME);
    tick(2);

    send(16'hC33C);
    tick(17);
    ena = 1'b0;
    tick(7);
    ena = 1'b1;
    wait_done("stall", n);
    check_int("stall_frame_len", 24 + n, FRAME + 7);
    tick(2);

    send(16'h1111);
    wait_done("b2b_first", n);
    send(16'h5A5A);
    check("b2b_busy", busy, 1'b1);
    check("b2b_tx", tx, 1'b0);
    wait_done("b2b_second", n);
    check_int("b2b_latency", n, FRAME);
    tick(2);

    send(16'h0107);
    wait_done("parity_word", n);
    check_int("parity_word_latency", n, FRAME);
    tick(2);

    repeat (3000) begin
      start = ($urandom_range(0, 19) == 0);
      data  = 16'($urandom);
      ena   = ($urandom_range(0, 9) != 0);
      tick();
    end
    start = 1'b0;
    ena   = 1'b1;
    tick(2 * FRAME);
    check_int("drain_queue", exp_q.size(), 0);
    check("drain_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_result_tx.md
Name: uart_result_tx

Overview:
- Serial transmit stage downstream of the FSM/ALU core.
- Takes a 16-bit ALU result on a start strobe and sends it on the `tx` pin as two 8N1 UART bytes, low byte first.
- Drives the `uart_tx` and `uart_busy` signals that the core exposes at the top level.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per UART bit period (50 MHz / 115200). Minimum legal value is 2.
- NUM_BYTES, 2: bytes per frame. Legal values are 1 or 2. Byte 0 is data[7:0]; byte 1 is data[15:8].

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- ena, input, 1: design enable. When low, the block freezes all state.
- start, input, 1: one-cycle request to send `data`.
- data, input, 16: ALU result to transmit.
- tx, output, 1: serial line. Idles high.
- busy, output, 1: high while a frame is in progress.
- done, output, 1: one-cycle pulse when the frame completes.

Behaviour:
- Reset (async, immediate):
  - tx=1, busy=0, done=0.
  - State goes to IDLE; bit counter, baud counter and byte index clear.
  - A reset mid-frame aborts the frame. tx returns high at once; no partial byte completes.
- All outputs are registered.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP, then either back to START for the next byte or to IDLE.
- IDLE:
  - tx=1, busy=0.
  - Accept when start=1 and ena=1: latch data into a 16-bit shift register, byte index=0, go to START.
  - The next cycle has tx=0 and busy=1 (one-cycle latency from accept to start bit).
- Bit timing:
  - Each bit is held on tx for exactly CLKS_PER_BIT enabled cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1 and wraps on the last cycle of each bit.
- START: tx=0 for one bit period, then go to DATA.
- DATA: 8 bits, LSB first. The bit counter runs 0..7, then the state advances.
- STOP:
  - tx=1 for one bit period.
  - At the end of the period: if byte index < NUM_BYTES-1, increment it, shift the next byte in, and go to START (no idle gap).
  - Otherwise go to IDLE, drop busy, and pulse done=1 for exactly one cycle.
- Frame length: NUM_BYTES × 10 × CLKS_PER_BIT cycles, or × 11 with parity enabled.
- busy stays high from the cycle after accept through the last cycle of the final stop bit.
- start while busy: ignored, with no queueing. data changes while busy are ignored (the value was latched at accept).
- start and done in the same cycle: done is asserted while busy is still 0 that cycle, so the new start is accepted. Back-to-back frames are legal.
- ena=0: baud counter, bit counter and state hold; tx holds its current level. Timing resumes where it left off when ena returns to 1. start is ignored while ena=0.

Optional Feature:
- Macro: UART_RESULT_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx carries even parity (XOR of the 8 data bits) for one bit period.
  - Each byte is 11 bits.
- When undefined: no PARITY state, 10-bit bytes, and no parity logic synthesised.

Test Plan:
- Basic frame (CLKS_PER_BIT=4, no parity): reset, then start=1 with data=16'h00A5 for one cycle.
  - tx sequence, each level held 4 cycles: 0,1,0,1,0,0,1,0,1,1 then 0,0,0,0,0,0,0,0,0,1.
  - busy is high for 80 cycles; done pulses on cycle 81.
- Ignored start: start with data=16'h1234, then start again at cycle 10 with data=16'hFFFF.
  - tx still carries bytes 34,12; only one done pulse occurs.
- Reset mid-frame: assert reset at cycle 25 of a 16'hBEEF frame.
  - tx=1, busy=0, done=0 in the same cycle.
  - After release, a fresh start with 16'h0001 transmits correctly.
- ena stall: drop ena for 7 cycles during bit 3 of byte 0.
  - tx holds level; the total frame is 87 cycles; the bit pattern is unchanged.
- Back-to-back: assert start in the done cycle with data=16'h5A5A.
  - The second frame's start bit begins the next cycle, with no idle-high gap beyond the stop bit.
- Parity (macro defined): data=16'h0107.
  - Byte 0 parity bit=1, byte 1 parity bit=1.
  - Frame is 88 cycles; done on cycle 89.
